tcpc_tx_scheduler: RTL and testbench

- Sequences every transmit request written to the TCPC TRANSMIT register onto the PD PHY: SOP* messages, Hard Reset and Cable Reset.
- Handles GoodCRC wait, retries and discard-on-receive.
- Drives one-cycle hardReset/cableReset strobes into the reset module and ALERT set-strobes into the alert register.
- Sits between the register file and the PHY transmitter.

---
 rtl/tcpc_pkg.sv | 43 ++++
 rtl/tcpc_tx_scheduler_if.sv | 20 ++
 rtl/tcpc_tx_timer.sv | 27 ++
 rtl/tcpc_tx_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_tcpc_tx_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcpc_pkg.sv
// Shared encodings for the TCPC transmit path: TRANSMIT fields, ALERT bit positions, scheduler states.
// Consumers: tcpc_tx_scheduler (optional watchdog enabled by TCPC_TX_WATCHDOG_EN).
package tcpc_pkg;

   localparam logic [2:0] TX_SOP       = 3'd0;
   localparam logic [2:0] TX_SOP_P     = 3'd1;
   localparam logic [2:0] TX_SOP_PP    = 3'd2;
   localparam logic [2:0] TX_DBG_P     = 3'd3;
   localparam logic [2:0] TX_DBG_PP    = 3'd4;
   localparam logic [2:0] TX_HARD_RST  = 3'd5;
   localparam logic [2:0] TX_CABLE_RST = 3'd6;
   localparam logic [2:0] TX_RSVD      = 3'd7;

   localparam int ALERT_TX_FAILED     = 4;
   localparam int ALERT_TX_DISCARDED  = 5;
   localparam int ALERT_TX_SUCCESSFUL = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_CRC,
      ST_RETRY,
      ST_SEND_RST,
      ST_REPORT
   } tx_state_t;

   function automatic logic [2:0] tx_type(input logic [7:0] transmit);
      return transmit[2:0];
   endfunction

   function automatic logic [1:0] tx_retry(input logic [7:0] transmit);
      return transmit[5:4];
   endfunction

   function automatic logic is_rst_type(input logic [2:0] t);
      return (t == TX_HARD_RST) || (t == TX_CABLE_RST);
   endfunction

   function automatic logic [15:0] alert_bit(input int idx);
      return 16'd1 << idx;
   endfunction

endpackage

// File: rtl/tcpc_tx_scheduler_if.sv
// PHY-side signals of the transmit scheduler: transmit handshake plus receiver status.
// master = scheduler, slave = PHY.
interface tcpc_tx_scheduler_if;
   logic       phy_tx_start;
   logic [2:0] phy_tx_sop;
   logic       phy_tx_done;
   logic       phy_goodcrc;
   logic       rx_busy;
   logic       rx_hard_reset;

   modport master (
      output phy_tx_start, phy_tx_sop,
      input  phy_tx_done, phy_goodcrc, rx_busy, rx_hard_reset
   );

   modport slave (
      input  phy_tx_start, phy_tx_sop,
      output phy_tx_done, phy_goodcrc, rx_busy, rx_hard_reset
   );
endinterface

// File: rtl/tcpc_tx_timer.sv
// Loadable down-counter that saturates at zero; zero flag is combinational from the count.
module tcpc_tx_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/tcpc_tx_scheduler.sv
// Sequences TRANSMIT requests (SOP*, Hard Reset, Cable Reset) onto the PD PHY with GoodCRC retries.
// Define TCPC_TX_WATCHDOG_EN to bound the phy_tx_start -> phy_tx_done wait by TX_TIMEOUT.
module tcpc_tx_scheduler
   import tcpc_pkg::*;
#(
   parameter int CRC_TIMEOUT = 900,
   parameter int TMR_W       = 10,
   parameter int TX_TIMEOUT  = 4000
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic [7:0]                 TRANSMIT,
   input  logic                       transmit_wr,
   tcpc_tx_scheduler_if.master        phy,
   output logic                       hardReset,
   output logic                       cableReset,
   output logic [15:0]                ALERT_SET,
   output logic                       tx_busy,
   output logic [1:0]                 retry_cnt
);

   tx_state_t   state_reg;
   logic [2:0]  type_reg;
   logic [1:0]  limit_reg;
   logic [1:0]  retry_cnt_reg;
   logic        sent_reg;
   logic        discard_pend_reg;
   logic        start_reg;
   logic [2:0]  sop_reg;
   logic        hard_reset_reg;
   logic        cable_reset_reg;
   logic [15:0] alert_reg;

   logic [2:0]  wr_type;
   logic [1:0]  wr_retry;
   logic        sop_in_flight;
   logic        crc_load;
   logic        crc_dec;
   logic        crc_zero;
   logic        wd_zero;
   logic        unused_transmit_bits;

   assign wr_type              = tx_type(TRANSMIT);
   assign wr_retry             = tx_retry(TRANSMIT);
   assign unused_transmit_bits = ^{TRANSMIT[7:6], TRANSMIT[3]};
   assign sop_in_flight        = (state_reg == ST_SEND) || (state_reg == ST_WAIT_CRC) ||
                                 (state_reg == ST_RETRY);

   // CRC timer is armed on the done strobe and counts down only while waiting for GoodCRC.
   assign crc_load = (state_reg == ST_SEND) && sent_reg && phy.phy_tx_done;
   assign crc_dec  = (state_reg == ST_WAIT_CRC);

   tcpc_tx_timer #(.W(TMR_W)) u_crc_timer (
      .clk      (CLK),
      .rst_n    (reset),
      .load     (crc_load),
      .load_val (TMR_W'(CRC_TIMEOUT)),
      .dec      (crc_dec),
      .zero     (crc_zero)
   );

`ifdef TCPC_TX_WATCHDOG_EN
   localparam int WD_W = $clog2(TX_TIMEOUT + 1);
   logic wd_load;
   logic wd_dec;
   assign wd_load = ((state_reg == ST_SEND) || (state_reg == ST_SEND_RST)) && !sent_reg;
   assign wd_dec  = ((state_reg == ST_SEND) || (state_reg == ST_SEND_RST)) && sent_reg;

   tcpc_tx_timer #(.W(WD_W)) u_wd_timer (
      .clk      (CLK),
      .rst_n    (reset),
      .load     (wd_load),
      .load_val (WD_W'(TX_TIMEOUT)),
      .dec      (wd_dec),
      .zero     (wd_zero)
   );
`else
   localparam int unused_tx_timeout = TX_TIMEOUT;
   assign wd_zero = 1'b0;
`endif

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_reg        <= ST_IDLE;
         type_reg         <= '0;
         limit_reg        <= '0;
         retry_cnt_reg    <= '0;
         sent_reg         <= 1'b0;
         discard_pend_reg <= 1'b0;
         start_reg        <= 1'b0;
         sop_reg          <= '0;
         hard_reset_reg   <= 1'b0;
         cable_reset_reg  <= 1'b0;
         alert_reg        <= '0;
      end else begin
         start_reg       <= 1'b0;
         hard_reset_reg  <= 1'b0;
         cable_reset_reg <= 1'b0;
         alert_reg       <= '0;

         if (phy.rx_hard_reset && (state_reg != ST_SEND_RST)) begin
            if (sop_in_flight) alert_reg <= alert_bit(ALERT_TX_DISCARDED);
            state_reg        <= ST_IDLE;
            retry_cnt_reg    <= '0;
            sent_reg         <= 1'b0;
            discard_pend_reg <= 1'b0;
            sop_reg          <= '0;
         end else if (transmit_wr && (state_reg != ST_IDLE) && is_rst_type(wr_type)) begin
            // Discard alert is deferred so it coincides with the reset strobe.
            type_reg         <= wr_type;
            discard_pend_reg <= sop_in_flight;
            retry_cnt_reg    <= '0;
            sent_reg         <= 1'b0;
            state_reg        <= ST_SEND_RST;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (transmit_wr) begin
                     type_reg         <= wr_type;
                     limit_reg        <= wr_retry;
                     retry_cnt_reg    <= '0;
                     sent_reg         <= 1'b0;
                     discard_pend_reg <= 1'b0;
                     if (is_rst_type(wr_type)) begin
                        state_reg <= ST_SEND_RST;
                     end else if (wr_type == TX_RSVD) begin
                        alert_reg <= alert_bit(ALERT_TX_FAILED);
                     end else if (phy.rx_busy) begin
                        alert_reg <= alert_bit(ALERT_TX_DISCARDED);
                        state_reg <= ST_REPORT;
                     end else begin
                        state_reg <= ST_SEND;
                     end
                  end
               end
               ST_SEND: begin
                  if (!sent_reg) begin
                     start_reg <= 1'b1;
                     sop_reg   <= type_reg;
                     sent_reg  <= 1'b1;
                  end else if (phy.phy_tx_done) begin
                     sent_reg  <= 1'b0;
                     state_reg <= ST_WAIT_CRC;
                  end else if (wd_zero) begin
                     sent_reg  <= 1'b0;
                     state_reg <= ST_RETRY;
                  end
               end
               ST_WAIT_CRC: begin
                  if (phy.phy_goodcrc) begin
                     alert_reg <= alert_bit(ALERT_TX_SUCCESSFUL);
                     state_reg <= ST_REPORT;
                  end else if (crc_zero) begin
                     state_reg <= ST_RETRY;
                  end
               end
               ST_RETRY: begin
                  if (phy.rx_busy) begin
                     alert_reg <= alert_bit(ALERT_TX_DISCARDED);
                     state_reg <= ST_REPORT;
                  end else if (retry_cnt_reg == limit_reg) begin
                     alert_reg <= alert_bit(ALERT_TX_FAILED);
                     state_reg <= ST_REPORT;
                  end else begin
                     retry_cnt_reg <= retry_cnt_reg + 2'd1;
                     state_reg     <= ST_SEND;
                  end
               end
               ST_SEND_RST: begin
                  if (!sent_reg) begin
                     start_reg        <= 1'b1;
                     sop_reg          <= type_reg;
                     sent_reg         <= 1'b1;
                     hard_reset_reg   <= (type_reg == TX_HARD_RST);
                     cable_reset_reg  <= (type_reg == TX_CABLE_RST);
                     discard_pend_reg <= 1'b0;
                     if (discard_pend_reg) alert_reg <= alert_bit(ALERT_TX_DISCARDED);
                  end else if (phy.phy_tx_done) begin
                     alert_reg <= alert_bit(ALERT_TX_FAILED) | alert_bit(ALERT_TX_SUCCESSFUL);
                     state_reg <= ST_REPORT;
                  end else if (wd_zero) begin
                     alert_reg <= alert_bit(ALERT_TX_FAILED);
                     state_reg <= ST_REPORT;
                  end
               end
               ST_REPORT: begin
                  state_reg     <= ST_IDLE;
                  retry_cnt_reg <= '0;
                  sent_reg      <= 1'b0;
                  sop_reg       <= '0;
               end
               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign phy.phy_tx_start = start_reg;
   assign phy.phy_tx_sop   = sop_reg;
   assign hardReset        = hard_reset_reg;
   assign cableReset       = cable_reset_reg;
   assign ALERT_SET        = alert_reg;
   assign tx_busy          = (state_reg != ST_IDLE);
   assign retry_cnt        = retry_cnt_reg;

endmodule

// File: tb/tb_tcpc_tx_scheduler.sv
// Directed bench for tcpc_tx_scheduler; ALERT_SET pulses are scoreboarded against expected values.
module tb_tcpc_tx_scheduler;

   localparam int CRC_TIMEOUT = 900;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] transmit = 8'h00;
   logic       transmit_wr = 1'b0;
   logic       hard_reset;
   logic       cable_reset;
   logic [15:0] alert_set;
   logic       tx_busy;
   logic [1:0] retry_cnt;

   tcpc_tx_scheduler_if phy_if();

   tcpc_tx_scheduler #(
      .CRC_TIMEOUT (CRC_TIMEOUT),
      .TMR_W       (10),
      .TX_TIMEOUT  (4000)
   ) dut (
      .CLK         (clk),
      .reset       (rst_n),
      .TRANSMIT    (transmit),
      .transmit_wr (transmit_wr),
      .phy         (phy_if),
      .hardReset   (hard_reset),
      .cableReset  (cable_reset),
      .ALERT_SET   (alert_set),
      .tx_busy     (tx_busy),
      .retry_cnt   (retry_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cnt = 0;
   int hr_cnt = 0;
   int cr_cnt = 0;
   logic [15:0] hr_alert = '0;
   logic [15:0] obs_q[$];
   logic [15:0] exp_q[$];
   int rd_idx = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (phy_if.phy_tx_start) start_cnt++;
      if (alert_set != 16'h0000) obs_q.push_back(alert_set);
      if (hard_reset) begin
         hr_cnt++;
         hr_alert = alert_set;
      end
      if (cable_reset) cr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_tx(input logic [7:0] v);
      @(posedge clk);
      #1;
      transmit    = v;
      transmit_wr = 1'b1;
      @(posedge clk);
      #1;
      transmit_wr = 1'b0;
   endtask

   task automatic pulse_done();
      @(posedge clk);
      #1 phy_if.phy_tx_done = 1'b1;
      @(posedge clk);
      #1 phy_if.phy_tx_done = 1'b0;
   endtask

   task automatic pulse_goodcrc();
      @(posedge clk);
      #1 phy_if.phy_goodcrc = 1'b1;
      @(posedge clk);
      #1 phy_if.phy_goodcrc = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int budget);
      int n;
      n = 0;
      sample();
      while (!phy_if.phy_tx_start && n < budget) begin
         sample();
         n++;
      end
      check(tag, 32'(phy_if.phy_tx_start), 32'd1);
   endtask

   task automatic expect_alerts(input string tag, input int budget);
      int n;
      logic [15:0] e;
      n = 0;
      while ((obs_q.size() - rd_idx) < exp_q.size() && n < budget) begin
         sample();
         n++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < obs_q.size()) begin
            check(tag, 32'(obs_q[rd_idx]), 32'(e));
            rd_idx++;
         end else begin
            check({tag, "_timeout"}, 32'hdead_beef, 32'(e));
         end
      end
   endtask

   initial begin
      int s0;
      int h0;
      int c0;
      int done_cyc;
      int gap;

      phy_if.phy_tx_done   = 1'b0;
      phy_if.phy_goodcrc   = 1'b0;
      phy_if.rx_busy       = 1'b0;
      phy_if.rx_hard_reset = 1'b0;

      // Reset state
      cycles(3);
      check("rst_alert", 32'(alert_set), 32'h0);
      check("rst_busy", {tx_busy, phy_if.phy_tx_start, hard_reset, cable_reset}, 32'h0);
      check("rst_sop_retry", {phy_if.phy_tx_sop, retry_cnt}, 32'h0);
      rst_n = 1'b1;
      cycles(2);

      // SOP, N=3, GoodCRC 50 cycles after done
      s0 = start_cnt;
      write_tx(8'h30);
      exp_q.push_back(16'h0040);
      sample();
      check("lat_start_early", 32'(phy_if.phy_tx_start), 32'd0);
      check("lat_busy", 32'(tx_busy), 32'd1);
      sample();
      check("lat_start", 32'(phy_if.phy_tx_start), 32'd1);
      check("lat_sop", 32'(phy_if.phy_tx_sop), 32'd0);
      cycles(2);
      pulse_done();
      cycles(49);
      pulse_goodcrc();
      @(negedge clk);
      check("crc_to_alert", 32'(alert_set), 32'h0040);
      expect_alerts("sop_success", 5);
      cycles(2);
      check("success_retry_clr", 32'(retry_cnt), 32'd0);
      check("success_idle", 32'(tx_busy), 32'd0);
      check("success_starts", 32'(start_cnt - s0), 32'd1);

      // N=2, no GoodCRC: three attempts then failure
      s0 = start_cnt;
      done_cyc = 0;
      write_tx(8'h20);
      exp_q.push_back(16'h0010);
      for (int i = 0; i < 3; i++) begin
         wait_start($sformatf("retry_start%0d", i), 2000);
         check($sformatf("retry_cnt%0d", i), 32'(retry_cnt), 32'(i));
         if (i > 0) begin
            gap = cyc - done_cyc;
            check($sformatf("retry_gap%0d", i),
                  32'((gap >= CRC_TIMEOUT) && (gap <= CRC_TIMEOUT + 8)), 32'd1);
         end
         cycles(2);
         pulse_done();
         done_cyc = cyc - 1;
      end
      expect_alerts("retry_fail", 1200);
      cycles(3);
      check("retry_starts", 32'(start_cnt - s0), 32'd3);

      // rx_busy at write time -> discard, no start
      s0 = start_cnt;
      phy_if.rx_busy = 1'b1;
      write_tx(8'h01);
      exp_q.push_back(16'h0020);
      expect_alerts("busy_discard", 10);
      phy_if.rx_busy = 1'b0;
      cycles(5);
      check("busy_no_start", 32'(start_cnt - s0), 32'd0);

      // Hard Reset written while waiting for GoodCRC
      h0 = hr_cnt;
      write_tx(8'h00);
      wait_start("hr_sop_start", 10);
      cycles(2);
      pulse_done();
      cycles(10);
      write_tx(8'h05);
      exp_q.push_back(16'h0020);
      exp_q.push_back(16'h0050);
      wait_start("hr_start", 10);
      check("hr_sop", 32'(phy_if.phy_tx_sop), 32'd5);
      check("hr_strobe", 32'(hard_reset), 32'd1);
      check("hr_alert_same_cycle", 32'(hr_alert), 32'h0020);
      cycles(3);
      pulse_done();
      expect_alerts("hr_seq", 10);
      check("hr_pulses", 32'(hr_cnt - h0), 32'd1);

      // Cable Reset from IDLE
      c0 = cr_cnt;
      write_tx(8'h06);
      exp_q.push_back(16'h0050);
      wait_start("cr_start", 10);
      check("cr_sop", 32'(phy_if.phy_tx_sop), 32'd6);
      check("cr_strobe", 32'(cable_reset), 32'd1);
      sample();
      check("cr_strobe_width", 32'(cable_reset), 32'd0);
      pulse_done();
      expect_alerts("cr_done", 5);
      check("cr_pulses", 32'(cr_cnt - c0), 32'd1);

      // GoodCRC on the cycle the CRC timer hits zero: success wins
      write_tx(8'h00);
      exp_q.push_back(16'h0040);
      wait_start("edge_start", 10);
      pulse_done();
      repeat (CRC_TIMEOUT - 1) @(posedge clk);
      #1 phy_if.phy_goodcrc = 1'b1;
      @(posedge clk);
      #1 phy_if.phy_goodcrc = 1'b0;
      expect_alerts("edge_success", 10);

      // Reserved type 7
      s0 = start_cnt;
      write_tx(8'h07);
      exp_q.push_back(16'h0010);
      expect_alerts("rsvd", 5);
      check("rsvd_no_start", 32'(start_cnt - s0), 32'd0);

      // rx_hard_reset while waiting for phy_tx_done
      s0 = start_cnt;
      write_tx(8'h10);
      wait_start("rxhr_start", 10);
      cycles(3);
      #1 phy_if.rx_hard_reset = 1'b1;
      @(posedge clk);
      #1 phy_if.rx_hard_reset = 1'b0;
      exp_q.push_back(16'h0020);
      expect_alerts("rxhr_discard", 5);
      cycles(20);
      pulse_done();
      cycles(CRC_TIMEOUT + 20);
      check("rxhr_no_restart", 32'(start_cnt - s0), 32'd1);
      check("rxhr_idle", 32'(tx_busy), 32'd0);

      // Async reset mid-WAIT_CRC
      write_tx(8'h30);
      wait_start("ar_start", 10);
      pulse_done();
      cycles(20);
      s0 = start_cnt;
      rst_n = 1'b0;
      #2;
      check("ar_alert", 32'(alert_set), 32'h0);
      check("ar_outs", {tx_busy, phy_if.phy_tx_start, hard_reset, cable_reset}, 32'h0);
      check("ar_sop_retry", {phy_if.phy_tx_sop, retry_cnt}, 32'h0);
      cycles(2);
      rst_n = 1'b1;
      cycles(4 * CRC_TIMEOUT);
      check("ar_no_start", 32'(start_cnt - s0), 32'd0);
      check("ar_idle", 32'(tx_busy), 32'd0);

      check("no_extra_alerts", 32'(obs_q.size() - rd_idx), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
